// File: rtl/alu_cmd_responder.sv
// rtl/alu_cmd_responder.sv - command/response wrapper that drives a combinational 32-bit ALU
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_A/B/Operator/n/tag          command payload
//   alu_A/B/Operator/n              registered operands to the ALU
//   alu_Result                      combinational result from the ALU
//   rsp_valid/rsp_ready             response handshake (FWFT FIFO head)
//   rsp_Result/rsp_tag/rsp_err      response payload, zero when rsp_valid=0
//   cmd_count                       accepted commands since reset, saturating
module alu_cmd_responder #(
   parameter int         DEPTH  = 4,
   parameter logic [3:0] MAX_OP = 4'b1010,
   parameter logic [5:0] MAX_N  = 6'd32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_A,
   input  logic [31:0] cmd_B,
   input  logic [3:0]  cmd_Operator,
   input  logic [5:0]  cmd_n,
   input  logic [3:0]  cmd_tag,
   output logic [31:0] alu_A,
   output logic [31:0] alu_B,
   output logic [3:0]  alu_Operator,
   output logic [5:0]  alu_n,
   input  logic [31:0] alu_Result,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_Result,
   output logic [3:0]  rsp_tag,
   output logic        rsp_err,
   output logic [15:0] cmd_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t        state_q;
   logic [31:0]   alu_a_q, alu_b_q;
   logic [3:0]    alu_op_q;
   logic [5:0]    alu_n_q;
   logic [3:0]    tag_q;
   logic          err_q;
   logic [15:0]   cmd_count_q, cmd_count_d;
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] fifo_count_q, fifo_count_d;

   // FIFO entry layout: {result[31:0], tag[3:0], err}
   logic [36:0]   mem_q [DEPTH];
   logic [36:0]   head;

   logic accept, legal, push, pop;

   // rst gates ready directly so nothing can be accepted while reset is held
   assign cmd_ready = !rst && (state_q == IDLE) && (fifo_count_q < FULL);
   assign accept    = cmd_valid && cmd_ready;
   assign legal     = (cmd_Operator <= MAX_OP) && (cmd_n <= MAX_N);

   // Space was reserved at accept, so an EXEC push always has room
   assign push      = (state_q == EXEC);
   assign pop       = (fifo_count_q != '0) && rsp_ready;

   always_comb begin
      fifo_count_d = fifo_count_q;
      case ({push, pop})
         2'b10:   fifo_count_d = fifo_count_q + 1'b1;
         2'b01:   fifo_count_d = fifo_count_q - 1'b1;
         default: fifo_count_d = fifo_count_q;
      endcase
   end

   always_comb begin
      cmd_count_d = cmd_count_q;
      if (accept && (cmd_count_q != 16'hFFFF))
         cmd_count_d = cmd_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         alu_op_q     <= '0;
         alu_n_q      <= '0;
         tag_q        <= '0;
         err_q        <= 1'b0;
         cmd_count_q  <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         fifo_count_q <= '0;
      end else begin
         cmd_count_q  <= cmd_count_d;
         fifo_count_q <= fifo_count_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  // Illegal commands leave the ALU operands untouched
                  if (legal) begin
                     alu_a_q  <= cmd_A;
                     alu_b_q  <= cmd_B;
                     alu_op_q <= cmd_Operator;
                     alu_n_q  <= cmd_n;
                  end
                  tag_q   <= cmd_tag;
                  err_q   <= !legal;
                  state_q <= EXEC;
               end
            end
            EXEC:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through fifo_count_q
   always_ff @(posedge clk) begin
      if (push)
         mem_q[wr_ptr_q] <= {(err_q ? 32'h0 : alu_Result), tag_q, err_q};
   end

   assign head       = mem_q[rd_ptr_q];
   assign rsp_valid  = (fifo_count_q != '0);
   assign rsp_Result = rsp_valid ? head[36:5] : 32'h0;
   assign rsp_tag    = rsp_valid ? head[4:1]  : 4'h0;
   assign rsp_err    = rsp_valid ? head[0]    : 1'b0;

   assign alu_A        = alu_a_q;
   assign alu_B        = alu_b_q;
   assign alu_Operator = alu_op_q;
   assign alu_n        = alu_n_q;
   assign cmd_count    = cmd_count_q;

endmodule

// File: tb/tb_alu_cmd_responder.sv
// tb/tb_alu_cmd_responder.sv - directed self-checking bench for alu_cmd_responder
module tb_alu_cmd_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_A = '0, cmd_B = '0;
   logic [3:0]  cmd_Operator = '0;
   logic [5:0]  cmd_n = '0;
   logic [3:0]  cmd_tag = '0;
   logic [31:0] alu_A, alu_B;
   logic [3:0]  alu_Operator;
   logic [5:0]  alu_n;
   logic [31:0] alu_Result;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_Result;
   logic [3:0]  rsp_tag;
   logic        rsp_err;
   logic [15:0] cmd_count;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   // Minimal ALU model: 0 = xor, 1 = add, anything else = or
   always_comb begin
      case (alu_Operator)
         4'b0000: alu_Result = alu_A ^ alu_B;
         4'b0001: alu_Result = alu_A + alu_B;
         default: alu_Result = alu_A | alu_B;
      endcase
   end

   alu_cmd_responder dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_Operator(cmd_Operator),
      .cmd_n(cmd_n), .cmd_tag(cmd_tag),
      .alu_A(alu_A), .alu_B(alu_B), .alu_Operator(alu_Operator),
      .alu_n(alu_n), .alu_Result(alu_Result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_Result(rsp_Result), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
      .cmd_count(cmd_count)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Called at a negedge; returns at the negedge after the accept edge (EXEC cycle)
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                       input logic [5:0] n, input logic [3:0] tag);
      cmd_A = a; cmd_B = b; cmd_Operator = op; cmd_n = n; cmd_tag = tag;
      cmd_valid = 1'b1;
      for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
      check("send_ready", {31'd0, cmd_ready}, 32'd1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      @(negedge clk);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_cmd_count", {16'd0, cmd_count}, 32'd0);
      check("rst_alu_A",     alu_A, 32'd0);
      check("rst_rsp_Result", rsp_Result, 32'd0);
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check("post_rst_ready", {31'd0, cmd_ready}, 32'd1);

      // 1: basic legal command
      @(negedge clk);
      send(32'h67085186, 32'h55B7D4C7, 4'b0000, 6'd32, 4'd3);
      check("t1_alu_A",  alu_A, 32'h67085186);
      check("t1_alu_B",  alu_B, 32'h55B7D4C7);
      check("t1_alu_op", {28'd0, alu_Operator}, 32'd0);
      check("t1_alu_n",  {26'd0, alu_n}, 32'd32);
      check("t1_exec_ready", {31'd0, cmd_ready}, 32'd0);
      check("t1_early_valid", {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      check("t1_valid",  {31'd0, rsp_valid}, 32'd1);
      check("t1_result", rsp_Result, 32'h32BF8541);
      check("t1_tag",    {28'd0, rsp_tag}, 32'd3);
      check("t1_err",    {31'd0, rsp_err}, 32'd0);
      check("t1_count",  {16'd0, cmd_count}, 32'd1);
      @(negedge clk);
      check("t1_popped", {31'd0, rsp_valid}, 32'd0);

      // 2: illegal opcode
      send(32'h1, 32'h2, 4'b1011, 6'd0, 4'd5);
      check("t2_alu_A",  alu_A, 32'h67085186);
      check("t2_alu_op", {28'd0, alu_Operator}, 32'd0);
      check("t2_alu_n",  {26'd0, alu_n}, 32'd32);
      @(negedge clk);
      check("t2_valid",  {31'd0, rsp_valid}, 32'd1);
      check("t2_result", rsp_Result, 32'h0);
      check("t2_tag",    {28'd0, rsp_tag}, 32'd5);
      check("t2_err",    {31'd0, rsp_err}, 32'd1);
      check("t2_count",  {16'd0, cmd_count}, 32'd2);
      @(negedge clk);

      // 3: illegal n (33)
      send(32'h5, 32'h6, 4'b0001, 6'd33, 4'd6);
      check("t3_alu_n",  {26'd0, alu_n}, 32'd32);
      check("t3_alu_op", {28'd0, alu_Operator}, 32'd0);
      @(negedge clk);
      check("t3_result", rsp_Result, 32'h0);
      check("t3_tag",    {28'd0, rsp_tag}, 32'd6);
      check("t3_err",    {31'd0, rsp_err}, 32'd1);
      check("t3_count",  {16'd0, cmd_count}, 32'd3);
      @(negedge clk);

      // 4: backpressure, FIFO fills at 4 entries
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(32'(i), 32'h10, 4'b0001, 6'd0, 4'(i));
      @(negedge clk);
      cmd_A = 32'd4; cmd_B = 32'h10; cmd_Operator = 4'b0001; cmd_n = 6'd0; cmd_tag = 4'd4;
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("t4_full_ready", {31'd0, cmd_ready}, 32'd0);
         @(negedge clk);
      end
      check("t4_count_hold", {16'd0, cmd_count}, 32'd7);
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("t4_drain_valid",  {31'd0, rsp_valid}, 32'd1);
         check("t4_drain_tag",    {28'd0, rsp_tag}, 32'(i));
         check("t4_drain_result", rsp_Result, 32'h10 + 32'(i));
         @(negedge clk);
      end
      check("t4_empty", {31'd0, rsp_valid}, 32'd0);
      send(32'd4, 32'h10, 4'b0001, 6'd0, 4'd4);
      @(negedge clk);
      check("t4_tag4",    {28'd0, rsp_tag}, 32'd4);
      check("t4_result4", rsp_Result, 32'h14);
      check("t4_count",   {16'd0, cmd_count}, 32'd8);
      @(negedge clk);

      // 5: streaming with cmd_valid held high for 8 commands
      for (int c = 0; c <= 16; c++) begin
         cmd_valid = (c < 16);
         cmd_A = 32'hA0 + 32'(c / 2); cmd_B = 32'h0; cmd_Operator = 4'b0000;
         cmd_n = 6'd1; cmd_tag = 4'(8 + c / 2);
         check("t5_ready", {31'd0, cmd_ready}, {31'd0, (c % 2) == 0});
         check("t5_valid", {31'd0, rsp_valid}, {31'd0, (c % 2) == 0 && c >= 2});
         if ((c % 2) == 0 && c >= 2) begin
            check("t5_tag",    {28'd0, rsp_tag}, 32'(8 + c / 2 - 1));
            check("t5_result", rsp_Result, 32'hA0 + 32'(c / 2 - 1));
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("t5_count", {16'd0, cmd_count}, 32'd16);

      // 6a: simultaneous push and pop keeps the count at 2
      rsp_ready = 1'b0;
      send(32'd1, 32'h10, 4'b0001, 6'd0, 4'd1);
      send(32'd2, 32'h10, 4'b0001, 6'd0, 4'd2);
      send(32'd3, 32'h10, 4'b0001, 6'd0, 4'd3);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      check("t6_pp_tag2", {28'd0, rsp_tag}, 32'd2);
      rsp_ready = 1'b1;
      @(negedge clk);
      check("t6_pp_tag3", {28'd0, rsp_tag}, 32'd3);
      @(negedge clk);
      check("t6_pp_empty", {31'd0, rsp_valid}, 32'd0);

      // 6b: reset in EXEC with 2 entries queued
      rsp_ready = 1'b0;
      send(32'd5, 32'h10, 4'b0001, 6'd0, 4'd5);
      send(32'd6, 32'h10, 4'b0001, 6'd0, 4'd6);
      send(32'd7, 32'h10, 4'b0001, 6'd0, 4'd7);
      rst = 1'b1;
      #1;
      check("t6_rst_valid", {31'd0, rsp_valid}, 32'd0);
      check("t6_rst_count", {16'd0, cmd_count}, 32'd0);
      check("t6_rst_alu_A", alu_A, 32'd0);
      check("t6_rst_alu_n", {26'd0, alu_n}, 32'd0);
      check("t6_rst_ready", {31'd0, cmd_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      rsp_ready = 1'b1;
      #1;
      check("t6_rel_ready", {31'd0, cmd_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t6_no_stale", {31'd0, rsp_valid}, 32'd0);
      end
      send(32'd5, 32'd3, 4'b0000, 6'd0, 4'd9);
      @(negedge clk);
      check("t6_new_tag",    {28'd0, rsp_tag}, 32'd9);
      check("t6_new_result", rsp_Result, 32'd6);
      check("t6_new_count",  {16'd0, cmd_count}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
